pc_redirect_unit: RTL

Fetch-stage program counter for the five-stage MIPS pipeline. It receives the resolved branch/jump decision from the D-stage comparator and turns it into the next fetch address. It implements the one-instruction delay slot, holds a taken redirect across F-stage stalls, and flags misaligned register-jump targets. It sits between the hazard unit, the D-stage comparator/decoder, and the instruction memory address port.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/npc_target.sv | 21 ++
 rtl/pc_redirect_unit.sv | 81 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and defaults for the fetch-stage PC logic
package pipe_pkg;
  typedef enum logic [1:0] {BR_REL = 2'd0, BR_J = 2'd1, BR_JR = 2'd2, BR_RSV = 2'd3} br_kind_e;
  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/npc_target.sv
// npc_target: combinational branch/jump target and JR alignment check
module npc_target
  import pipe_pkg::*;
(
  input  logic [1:0]  br_kind,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] target,
  output logic        misaligned
);
  logic [31:0] w_pc4;
  logic [31:0] w_rel;
  assign w_pc4      = d_pc + 32'd4;
  assign w_rel      = w_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign target     = (br_kind == BR_REL) ? w_rel :
                      (br_kind == BR_J)   ? {w_pc4[31:28], instr_index, 2'b00} :
                                            {rs_val[31:2], 2'b00};
  assign misaligned = (br_kind == BR_JR) && (rs_val[1:0] != 2'b00);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC with delay-slot redirect, stall-held target and JR alignment flag
module pc_redirect_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [1:0]  br_kind,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] pc_f,
  output logic        redirect,
  output logic        pending,
  output logic        align_err
);
  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic        r_redirect;
  logic        r_align_err;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_take;

  npc_target u_npc_target (
    .br_kind     (br_kind),
    .d_pc        (d_pc),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .target      (w_target),
    .misaligned  (w_misaligned)
  );

  assign w_take = br_valid && br_taken && (br_kind != BR_RSV);

  // The D stage is frozen in HOLD, so branch inputs only matter in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_tgt       <= 32'd0;
      r_redirect  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_take && w_misaligned) r_align_err <= 1'b1;
          if (w_take && !stall) begin
            r_pc       <= w_target;
            r_redirect <= 1'b1;
          end else if (w_take) begin
            r_tgt   <= w_target;
            r_state <= ST_HOLD;
          end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        default: begin
          if (!stall) begin
            r_pc       <= r_tgt;
            r_redirect <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign pc_f      = r_pc;
  assign redirect  = r_redirect;
  assign pending   = (r_state == ST_HOLD);
  assign align_err = r_align_err;
endmodule
